// File: rtl/drp_multi_ctrl_pkg.sv
// Shared types and helpers for the multi-port DRP command controller.
package drp_multi_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RSP  = 2'd3
  } state_t;

  // Widest DRP data word the merge helper supports.
  localparam int MERGE_W = 64;

  // Masked read-modify-write merge: bits set in mask come from data,
  // the remaining bits keep their old value.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0] old,
    input logic [MERGE_W-1:0] data,
    input logic [MERGE_W-1:0] mask
  );
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/drp_multi_ctrl.sv
// Command-driven DRP master for NUM_CH reconfiguration ports sharing one
// clock. One transaction in flight; supports masked read-modify-write and a
// DRDY timeout. DRP address/data/write-enable are shared, DEN is per channel.
module drp_multi_ctrl
  import drp_multi_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_cmd_valid,
  output logic                          s_cmd_ready,
  input  logic                          s_cmd_write,
  input  logic [CH_BITS-1:0]            s_cmd_ch,
  input  logic [ADDR_BITS-1:0]          s_cmd_addr,
  input  logic [DATA_BITS-1:0]          s_cmd_data,
  input  logic [DATA_BITS-1:0]          s_cmd_mask,
  output logic                          m_rsp_valid,
  input  logic                          m_rsp_ready,
  output logic [DATA_BITS-1:0]          m_rsp_data,
  output logic                          m_rsp_err,
  output logic [NUM_CH-1:0]             drp_den,
  output logic                          drp_dwe,
  output logic [ADDR_BITS-1:0]          drp_daddr,
  output logic [DATA_BITS-1:0]          drp_di,
  input  logic [NUM_CH*DATA_BITS-1:0]   drp_do,
  input  logic [NUM_CH-1:0]             drp_drdy,
  output logic                          busy
);

  // Timeout counter is wide enough to hold TIMEOUT itself.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                 state_r;
  logic [CH_BITS-1:0]     ch_r;
  logic                   write_r;
  logic [DATA_BITS-1:0]   data_r;
  logic [DATA_BITS-1:0]   mask_r;
  logic [CNT_W-1:0]       cnt_r;

  logic                   rsp_valid_r;
  logic [DATA_BITS-1:0]   rsp_data_r;
  logic                   rsp_err_r;
  logic [NUM_CH-1:0]      den_r;
  logic                   dwe_r;
  logic [ADDR_BITS-1:0]   daddr_r;
  logic [DATA_BITS-1:0]   di_r;

  logic [NUM_CH-1:0]      cmd_oh_s;
  logic [NUM_CH-1:0]      ch_oh_s;
  logic [DATA_BITS-1:0]   rd_data_s;
  logic                   drdy_s;
  logic                   illegal_s;
  logic                   timeout_s;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic [DATA_BITS-1:0]   merged_s;

  // Channel decode for the incoming and latched channel, plus the
  // read-data / ready mux of the selected channel (other channels ignored).
  always_comb begin
    cmd_oh_s  = '0;
    ch_oh_s   = '0;
    rd_data_s = '0;
    drdy_s    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmd_oh_s[i] = (s_cmd_ch == CH_BITS'(i));
      ch_oh_s[i]  = (ch_r == CH_BITS'(i));
      rd_data_s   = rd_data_s | (drp_do[i*DATA_BITS +: DATA_BITS] & {DATA_BITS{ch_oh_s[i]}});
      drdy_s      = drdy_s | (drp_drdy[i] & ch_oh_s[i]);
    end
  end

  // A channel index that matches no port is illegal; the counter expiring
  // is the cycle whose increment would reach TIMEOUT. Counter saturates.
  always_comb begin
    illegal_s = ~(|cmd_oh_s);
    timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    cnt_inc_s = (cnt_r == CNT_W'(TIMEOUT)) ? cnt_r : (cnt_r + CNT_W'(1));
    merged_s  = DATA_BITS'(merge(MERGE_W'(rd_data_s), MERGE_W'(data_r), MERGE_W'(mask_r)));
  end

  // Main controller FSM with its datapath and registered DRP/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ch_r        <= '0;
      write_r     <= 1'b0;
      data_r      <= '0;
      mask_r      <= '0;
      cnt_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      den_r       <= '0;
      dwe_r       <= 1'b0;
      daddr_r     <= '0;
      di_r        <= '0;
    end else begin
      // DEN is a single-cycle strobe unless re-armed below.
      den_r <= '0;
      case (state_r)
        IDLE: begin
          if (s_cmd_valid) begin
            ch_r       <= s_cmd_ch;
            write_r    <= s_cmd_write;
            data_r     <= s_cmd_data;
            mask_r     <= s_cmd_mask;
            cnt_r      <= '0;
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b0;
            if (illegal_s) begin
              state_r     <= RSP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
            end else if (!s_cmd_write || (s_cmd_mask != '1)) begin
              // Reads and masked writes both start with a DRP read.
              state_r <= RD;
              den_r   <= cmd_oh_s;
              dwe_r   <= 1'b0;
              daddr_r <= s_cmd_addr;
            end else begin
              state_r <= WR;
              den_r   <= cmd_oh_s;
              dwe_r   <= 1'b1;
              daddr_r <= s_cmd_addr;
              di_r    <= s_cmd_data;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          if (drdy_s) begin
            rsp_data_r <= rd_data_s;
            if (!write_r) begin
              state_r     <= RSP;
              rsp_valid_r <= 1'b1;
            end else begin
              // Second access of a read-modify-write: write the merged word.
              state_r <= WR;
              den_r   <= ch_oh_s;
              dwe_r   <= 1'b1;
              di_r    <= merged_s;
              cnt_r   <= '0;
            end
          end else if (timeout_s) begin
            state_r     <= RSP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= '0;
            cnt_r       <= cnt_inc_s;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        WR: begin
          if (drdy_s) begin
            state_r     <= RSP;
            rsp_valid_r <= 1'b1;
          end else if (timeout_s) begin
            state_r     <= RSP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= '0;
            cnt_r       <= cnt_inc_s;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        RSP: begin
          if (m_rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r <= RSP;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign s_cmd_ready = ~reset & (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign m_rsp_valid = rsp_valid_r;
  assign m_rsp_data  = rsp_data_r;
  assign m_rsp_err   = rsp_err_r;
  assign drp_den     = den_r;
  assign drp_dwe     = dwe_r;
  assign drp_daddr   = daddr_r;
  assign drp_di      = di_r;

endmodule

// File: tb/tb_drp_multi_ctrl.sv
// Self-checking bench for drp_multi_ctrl: directed scenarios plus random
// transactions, checked against a cycle-schedule model of the DRP protocol
// and a per-channel register-file model of the DRP slaves.
module tb_drp_multi_ctrl;

  localparam int NUM_CH  = 2;
  localparam int CH_BITS = 2;
  localparam int TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  s_cmd_valid;
  logic                  s_cmd_ready;
  logic                  s_cmd_write;
  logic [CH_BITS-1:0]    s_cmd_ch;
  logic [6:0]            s_cmd_addr;
  logic [15:0]           s_cmd_data;
  logic [15:0]           s_cmd_mask;
  logic                  m_rsp_valid;
  logic                  m_rsp_ready;
  logic [15:0]           m_rsp_data;
  logic                  m_rsp_err;
  logic [NUM_CH-1:0]     drp_den;
  logic                  drp_dwe;
  logic [6:0]            drp_daddr;
  logic [15:0]           drp_di;
  logic [NUM_CH*16-1:0]  drp_do;
  logic [NUM_CH-1:0]     drp_drdy;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:NUM_CH-1][0:127];

  drp_multi_ctrl #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .ADDR_BITS(7), .DATA_BITS(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_write(s_cmd_write),
    .s_cmd_ch(s_cmd_ch), .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_mask(s_cmd_mask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Random DRP read data on every channel.
  task automatic drive_junk_do();
    for (int i = 0; i < NUM_CH; i++) drp_do[i*16 +: 16] = 16'($urandom);
  endtask

  // One command end to end. k1/k2: DRDY delay (cycles after DEN) for the
  // first/second DRP access; <=0 means the slave never answers.
  // hold: cycles the response is back-pressured.
  task automatic txn(input bit wr, input int ch, input logic [6:0] addr,
                     input logic [15:0] data, input logic [15:0] mask,
                     input int k1, input int k2, input int hold);
    bit legal, rmw, exp_err;
    logic [15:0] old, exp_data, exp_di2;
    logic [NUM_CH-1:0] sel, exp_den;
    int d1, d2, r1, r2, rc;
    legal    = (ch >= 0) && (ch < NUM_CH);
    rmw      = wr && (mask != 16'hFFFF);
    old      = legal ? mem[ch][addr] : 16'h0000;
    sel      = legal ? (NUM_CH'(1) << ch) : '0;
    exp_di2  = (old & ~mask) | (data & mask);
    exp_err  = 1'b0;
    exp_data = 16'h0000;
    d1 = -1; d2 = -1; r1 = -1; r2 = -1; rc = 1;
    if (!legal) begin
      rc = 1;
      exp_err = 1'b1;
    end else begin
      d1 = 1;
      r1 = (k1 > 0) ? 1 + k1 : -1;
      if (k1 <= 0 || k1 >= TIMEOUT) begin
        rc = 1 + TIMEOUT;
        exp_err = 1'b1;
      end else if (!rmw) begin
        rc = 2 + k1;
        if (!wr) exp_data = old;
        else mem[ch][addr] = data;
      end else begin
        d2 = 2 + k1;
        r2 = (k2 > 0) ? d2 + k2 : -1;
        if (k2 <= 0 || k2 >= TIMEOUT) begin
          rc = d2 + TIMEOUT;
          exp_err = 1'b1;
        end else begin
          rc = d2 + k2 + 1;
          exp_data = old;
          mem[ch][addr] = exp_di2;
        end
      end
    end

    // cycle 0: present the command
    chk("cmd_ready_idle", 32'(s_cmd_ready), 32'(1));
    s_cmd_valid = 1'b1;
    s_cmd_write = wr;
    s_cmd_ch    = CH_BITS'(ch);
    s_cmd_addr  = addr;
    s_cmd_data  = data;
    s_cmd_mask  = mask;
    tick();
    s_cmd_valid = 1'b0;
    s_cmd_write = 1'($urandom);
    s_cmd_ch    = CH_BITS'($urandom);
    s_cmd_addr  = 7'($urandom);
    s_cmd_data  = 16'($urandom);
    s_cmd_mask  = 16'($urandom);

    for (int c = 1; c <= rc; c++) begin
      exp_den = (c == d1 || c == d2) ? sel : '0;
      chk("den", 32'(drp_den), 32'(exp_den));
      if (c == d1) begin
        chk("daddr1", 32'(drp_daddr), 32'(addr));
        chk("dwe1", 32'(drp_dwe), 32'(wr && !rmw));
        if (wr && !rmw) chk("di_plain", 32'(drp_di), 32'(data));
      end
      if (c == d2) begin
        chk("daddr2", 32'(drp_daddr), 32'(addr));
        chk("dwe2", 32'(drp_dwe), 32'(1));
        chk("di_merge", 32'(drp_di), 32'(exp_di2));
      end
      chk("rsp_valid_t", 32'(m_rsp_valid), 32'(c == rc));
      chk("busy", 32'(busy), 32'(1));
      chk("cmd_ready_busy", 32'(s_cmd_ready), 32'(0));
      // spurious DRDY on non-selected channels; selected only on schedule
      drive_junk_do();
      drp_drdy = NUM_CH'($urandom) & ~sel;
      if (legal && (c == r1 || c == r2)) begin
        drp_drdy = drp_drdy | sel;
        if (c == r1) drp_do[ch*16 +: 16] = old;
      end
      if (c < rc) tick();
    end
    chk("rsp_data", 32'(m_rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(m_rsp_err), 32'(exp_err));

    // back-pressure: every DRDY fires, all must be ignored
    m_rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      drp_drdy = '1;
      drive_junk_do();
      tick();
      chk("hold_valid", 32'(m_rsp_valid), 32'(1));
      chk("hold_data", 32'(m_rsp_data), 32'(exp_data));
      chk("hold_err", 32'(m_rsp_err), 32'(exp_err));
      chk("hold_cmd_ready", 32'(s_cmd_ready), 32'(0));
      chk("hold_den", 32'(drp_den), 32'(0));
    end
    m_rsp_ready = 1'b1;
    drp_drdy = '0;
    tick();
    m_rsp_ready = 1'b0;
    chk("post_valid", 32'(m_rsp_valid), 32'(0));
    chk("post_cmd_ready", 32'(s_cmd_ready), 32'(1));
    chk("post_busy", 32'(busy), 32'(0));
  endtask

  function automatic int pick_k();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return TIMEOUT;
    if (r == 1) return TIMEOUT - 1;
    return int'($urandom_range(1, 4));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    int          ch;
    logic [15:0] mask;
    for (int i = 0; i < NUM_CH; i++)
      for (int a = 0; a < 128; a++) mem[i][a] = 16'($urandom);
    reset = 1'b1;
    s_cmd_valid = 1'b0; s_cmd_write = 1'b0; s_cmd_ch = '0; s_cmd_addr = 7'h00;
    s_cmd_data = 16'h0000; s_cmd_mask = 16'h0000; m_rsp_ready = 1'b0;
    drp_do = '0; drp_drdy = '0;
    tick(); tick(); tick();

    // reset values
    chk("rst_cmd_ready", 32'(s_cmd_ready), 32'(0));
    chk("rst_valid", 32'(m_rsp_valid), 32'(0));
    chk("rst_err", 32'(m_rsp_err), 32'(0));
    chk("rst_data", 32'(m_rsp_data), 32'(0));
    chk("rst_den", 32'(drp_den), 32'(0));
    chk("rst_dwe", 32'(drp_dwe), 32'(0));
    chk("rst_daddr", 32'(drp_daddr), 32'(0));
    chk("rst_di", 32'(drp_di), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'(s_cmd_ready), 32'(1));

    // read ch1 addr 0x08, DRDY 3 cycles after DEN, response at cycle 5
    mem[1][8] = 16'h1234;
    txn(1'b0, 1, 7'h08, 16'h0000, 16'h0000, 3, 0, 0);
    // RMW ch0 addr 0x14: old A5A5, data 0F0F, mask 00FF -> writes A50F
    mem[0][20] = 16'hA5A5;
    txn(1'b1, 0, 7'h14, 16'h0F0F, 16'h00FF, 2, 2, 1);
    txn(1'b0, 0, 7'h14, 16'h0000, 16'h0000, 1, 0, 0);
    // plain write ch0, slave never answers -> timeout; late DRDY in hold
    txn(1'b1, 0, 7'h22, 16'hBEEF, 16'hFFFF, 0, 0, 4);
    txn(1'b0, 0, 7'h22, 16'h0000, 16'h0000, 2, 0, 0);
    // illegal channels
    txn(1'b0, 3, 7'h01, 16'h0000, 16'h0000, 1, 0, 2);
    txn(1'b1, 2, 7'h02, 16'h1111, 16'hFFFF, 1, 0, 0);
    // long back-pressure on a ch1 read (spurious ch0 DRDY during the read)
    txn(1'b0, 1, 7'h30, 16'h0000, 16'h0000, 4, 0, 10);
    // DRDY on the very cycle the counter would expire wins
    txn(1'b0, 1, 7'h31, 16'h0000, 16'h0000, TIMEOUT - 1, 0, 0);
    // DRDY one cycle too late -> timeout
    txn(1'b0, 1, 7'h31, 16'h0000, 16'h0000, TIMEOUT, 0, 0);
    // RMW whose write phase times out
    txn(1'b1, 1, 7'h32, 16'hFFFF, 16'hF000, 1, 0, 0);

    // reset the cycle after DEN: no response, next command served
    s_cmd_valid = 1'b1; s_cmd_write = 1'b0; s_cmd_ch = 2'd0; s_cmd_addr = 7'h05;
    tick();
    s_cmd_valid = 1'b0;
    chk("mid_den", 32'(drp_den), 32'(1));
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_den", 32'(drp_den), 32'(0));
    chk("mid_rst_valid", 32'(m_rsp_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(s_cmd_ready), 32'(0));
    reset = 1'b0;
    drp_drdy = 2'b01;
    tick();
    drp_drdy = '0;
    chk("after_rst_valid", 32'(m_rsp_valid), 32'(0));
    chk("after_rst_ready", 32'(s_cmd_ready), 32'(1));
    txn(1'b0, 0, 7'h05, 16'h0000, 16'h0000, 2, 0, 1);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      ch   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      mask = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      txn(wr, ch, 7'($urandom), 16'($urandom), mask, pick_k(), pick_k(),
          int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
